// File: rtl/video_line_scheduler.sv
`timescale 1ns/1ps
// video_line_scheduler
//
// Output-domain controller for the scaler's line-buffer ring. It tells the
// input writer which ring slot to fill next and tells the HDMI read side which
// slot to display on every 720p output line. Each source line is shown on
// V_SCALE consecutive output lines, the picture is vertically centred starting
// at V_OFFSET, the ring is primed before display begins, and ring occupancy is
// pulled back to PRIME at every output frame start so latency stays bounded.
// All source-side events arrive as single-cycle pulses already synchronised
// into the clk_out domain.
//
// Ports:
//   clk_out         output pixel clock (74.25 MHz)
//   reset           asynchronous, active-high reset
//   enable          run enable; low returns the scheduler to WAIT_SRC
//   src_frame_start source vsync pulse
//   src_line_done   pulse: writer finished filling wr_slot
//   out_line_start  pulse at h_count==0 of each output line
//   out_line_num    output v_count, valid with out_line_start
//   wr_slot         slot the writer fills next
//   wr_allow        ring has a free slot (fill_level < SLOTS)
//   rd_slot         slot the read side displays
//   rd_valid        current output line carries picture
//   rd_src_line     source line index being displayed
//   fill_level      number of occupied slots
//   underrun_pulse  one-cycle flag: release wanted but ring nearly empty
//   overflow_pulse  one-cycle flag: write arrived with ring full
//   underrun_count  saturating count of underruns
module video_line_scheduler #(
   parameter int SLOTS     = 4,
   parameter int SLOT_W    = 2,
   parameter int V_SCALE   = 3,
   parameter int SRC_LINES = 224,
   parameter int V_OFFSET  = 24,
   parameter int PRIME     = 2
) (
   input  logic              clk_out,
   input  logic              reset,
   input  logic              enable,
   input  logic              src_frame_start,
   input  logic              src_line_done,
   input  logic              out_line_start,
   input  logic [9:0]        out_line_num,
   output logic [SLOT_W-1:0] wr_slot,
   output logic              wr_allow,
   output logic [SLOT_W-1:0] rd_slot,
   output logic              rd_valid,
   output logic [8:0]        rd_src_line,
   output logic [SLOT_W:0]   fill_level,
   output logic              underrun_pulse,
   output logic              overflow_pulse,
   output logic [15:0]       underrun_count
);

   localparam int REP_W = $clog2(V_SCALE + 1);

   localparam logic [SLOT_W:0]   SLOTS_F    = (SLOT_W+1)'(SLOTS);
   localparam logic [SLOT_W:0]   PRIME_F    = (SLOT_W+1)'(PRIME);
   localparam logic [SLOT_W:0]   ONE_F      = (SLOT_W+1)'(1);
   localparam logic [SLOT_W-1:0] PRIME_S    = SLOT_W'(PRIME);
   localparam logic [9:0]        LINE_FIRST = 10'(V_OFFSET);
   localparam logic [9:0]        LINE_END   = 10'(V_OFFSET + SRC_LINES * V_SCALE);
   localparam logic [8:0]        LAST_SRC   = 9'(SRC_LINES - 1);
   localparam logic [REP_W-1:0]  REP_LAST   = REP_W'(V_SCALE - 1);

   typedef enum logic [1:0] {
      ST_WAIT_SRC,
      ST_PRIME,
      ST_WAIT_OUT,
      ST_RUN
   } state_t;

   state_t           state;
   logic [REP_W-1:0] rep;

   logic             line_active;
   logic             read_evt;
   logic             recentre;
   logic             active_evt;
   logic             rep_wrap;
   logic             release_req;
   logic             do_release;
   logic             do_underrun;
   logic             do_skip;
   logic [SLOT_W-1:0] skip_amt;
   logic             write_side;
   logic             wr_accept;
   logic             wr_overflow;
   logic [SLOT_W:0]  fill_base;
   logic [SLOT_W:0]  fill_next;

   // Decode this cycle's read and write events and the resulting ring fill.
   // The first active line of a frame only starts displaying the current
   // slot; every later active line advances the repeat counter, and the
   // counter wrapping means the displayed source line is finished and its
   // slot can be handed back to the writer. A write is still accepted into a
   // full ring when the same cycle frees a slot (release or re-centre skip),
   // so a coincident write and release leaves fill unchanged.
   always_comb begin
      line_active = (out_line_num >= LINE_FIRST) && (out_line_num < LINE_END);
      read_evt    = (state == ST_RUN) && out_line_start;
      recentre    = read_evt && (out_line_num == 10'd0);
      active_evt  = read_evt && !recentre && line_active;
      rep_wrap    = active_evt && (out_line_num != LINE_FIRST) && (rep == REP_LAST);
      release_req = rep_wrap && (rd_src_line != LAST_SRC);
      do_release  = release_req && (fill_level > ONE_F);
      do_underrun = release_req && !(fill_level > ONE_F);
      do_skip     = recentre && (fill_level > PRIME_F);
      skip_amt    = fill_level[SLOT_W-1:0] - PRIME_S;
      write_side  = (state != ST_WAIT_SRC);
      wr_accept   = write_side && src_line_done &&
                    ((fill_level < SLOTS_F) || do_release || do_skip);
      wr_overflow = write_side && src_line_done && !wr_accept;
      fill_base   = fill_level;
      if (do_skip) begin
         fill_base = PRIME_F;
      end else if (do_release) begin
         fill_base = fill_level - ONE_F;
      end
      fill_next   = fill_base + {{SLOT_W{1'b0}}, wr_accept};
   end

   // Scheduler state machine and all registered outputs. Dropping enable
   // abandons the current frame from any state; the scheduler then waits for
   // the next source vsync before priming the ring again.
   always_ff @(posedge clk_out or posedge reset) begin
      if (reset) begin
         state          <= ST_WAIT_SRC;
         wr_slot        <= '0;
         rd_slot        <= '0;
         fill_level     <= '0;
         rd_src_line    <= '0;
         rep            <= '0;
         rd_valid       <= 1'b0;
         wr_allow       <= 1'b1;
         underrun_pulse <= 1'b0;
         overflow_pulse <= 1'b0;
         underrun_count <= '0;
      end else begin
         underrun_pulse <= 1'b0;
         overflow_pulse <= 1'b0;
         if (!enable) begin
            state       <= ST_WAIT_SRC;
            wr_slot     <= '0;
            rd_slot     <= '0;
            fill_level  <= '0;
            rd_src_line <= '0;
            rep         <= '0;
            rd_valid    <= 1'b0;
            wr_allow    <= 1'b1;
         end else if (state == ST_WAIT_SRC) begin
            if (src_frame_start) begin
               state       <= ST_PRIME;
               wr_slot     <= '0;
               rd_slot     <= '0;
               fill_level  <= '0;
               rd_src_line <= '0;
               rep         <= '0;
               rd_valid    <= 1'b0;
               wr_allow    <= 1'b1;
            end
         end else begin
            if (wr_accept) begin
               wr_slot <= wr_slot + 1'b1;
            end
            overflow_pulse <= wr_overflow;
            fill_level     <= fill_next;
            wr_allow       <= (fill_next < SLOTS_F);

            if ((state == ST_PRIME) && (fill_next >= PRIME_F)) begin
               state <= ST_WAIT_OUT;
            end

            if ((state == ST_WAIT_OUT) && out_line_start && (out_line_num == 10'd0)) begin
               state       <= ST_RUN;
               rep         <= '0;
               rd_src_line <= '0;
               rd_valid    <= line_active;
            end

            if (read_evt) begin
               rd_valid <= line_active;
               if (recentre) begin
                  rd_src_line <= '0;
                  rep         <= '0;
                  // Drop the oldest buffered lines so the new frame starts
                  // with exactly PRIME lines of latency.
                  if (do_skip) begin
                     rd_slot <= rd_slot + skip_amt;
                  end
               end else if (active_evt) begin
                  if (out_line_num == LINE_FIRST) begin
                     rep <= '0;
                  end else if (rep == REP_LAST) begin
                     rep <= '0;
                  end else begin
                     rep <= rep + 1'b1;
                  end
                  if (do_release) begin
                     rd_slot     <= rd_slot + 1'b1;
                     rd_src_line <= rd_src_line + 1'b1;
                  end
                  if (do_underrun) begin
                     underrun_pulse <= 1'b1;
                     if (underrun_count != 16'hFFFF) begin
                        underrun_count <= underrun_count + 16'd1;
                     end
                  end
               end
            end
         end
      end
   end

endmodule
